// File: rtl/toggle_handshake_responder_pkg.sv
// Shared types and defaults for the toggle-handshake receive link.
package toggle_handshake_responder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DATA_W      = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/toggle_handshake_responder_sync.sv
// Toggle synchronizer plus flip detector; also usable on the initiator's ack return path.
module toggle_sync
  import toggle_handshake_responder_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic r,
  input  logic i_async,
  output logic sync_q,
  output logic chg
);

  // Fewer than two stages is not a synchronizer; silently raise to the floor.
  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_chg;

  // chg is registered, adding one edge so the total latency is STAGES+2 edges.
  always_ff @(posedge clk) begin
    if (r) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_chg  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
      r_chg  <= r_sync[STAGES-1] ^ r_prev;
    end
  end

  assign sync_q = r_sync[STAGES-1];
  assign chg    = r_chg;

endmodule

// File: rtl/toggle_handshake_responder.sv
// Receive end of a two-phase req/ack link: detects request flips, presents data via valid/ready.
module toggle_handshake_responder
  import toggle_handshake_responder_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              r,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              ack_tgl,
  output logic [CNT_W-1:0]  event_count,
  output logic              busy,
  output logic              err
);

  logic w_sync_q;
  logic w_chg;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .r       (r),
    .i_async (req_tgl),
    .sync_q  (w_sync_q),
    .chg     (w_chg)
  );

  state_t            r_state, w_state_nxt;
  logic              r_valid, w_valid_nxt;
  logic [DATA_W-1:0] r_data,  w_data_nxt;
  logic              r_ack,   w_ack_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic              r_err,   w_err_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_ack_nxt   = r_ack;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_chg) begin
          w_data_nxt  = req_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = VALID;
        end
      end
      VALID: begin
        if (ready) begin
          w_ack_nxt = ~r_ack;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_chg) begin
            w_data_nxt = req_data;  // back-to-back: next event takes the slot
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end
        end else if (w_chg) begin
          // Initiator flipped again before the ack; that flip is lost.
          w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_ack   <= w_ack_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign valid       = r_valid;
  assign data        = r_data;
  assign ack_tgl     = r_ack;
  assign event_count = r_cnt;
  assign busy        = r_valid;
  assign err         = r_err;

  logic w_unused;
  assign w_unused = w_sync_q;

endmodule

// File: tb/tb_toggle_handshake_responder.sv
// Directed bench for toggle_handshake_responder with immediate-assertion checks.
module tb_toggle_handshake_responder;

  logic       clk;
  logic       r;
  logic       req_tgl;
  logic [3:0] req_data;
  logic       ready;
  logic       valid;
  logic [3:0] data;
  logic       ack_tgl;
  logic [7:0] event_count;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;

  toggle_handshake_responder #(.SYNC_STAGES(2), .DATA_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .r           (r),
    .req_tgl     (req_tgl),
    .req_data    (req_data),
    .ready       (ready),
    .valid       (valid),
    .data        (data),
    .ack_tgl     (ack_tgl),
    .event_count (event_count),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [3:0] d,
                         input logic a, input logic [7:0] c, input logic e);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".busy"},  32'(busy),  32'(v));
    chk({tag, ".data"},  32'(data),  32'(d));
    chk({tag, ".ack"},   32'(ack_tgl), 32'(a));
    chk({tag, ".cnt"},   32'(event_count), 32'(c));
    chk({tag, ".err"},   32'(err),   32'(e));
  endtask

  initial begin
    r = 1'b1; req_tgl = 1'b0; req_data = 4'h0; ready = 1'b0;
    tick(); tick();
    chk_all("reset", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);

    // Idle after reset release
    r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    end

    // Single event, consumer ready: valid on the 4th edge, one cycle wide
    req_data = 4'hA; ready = 1'b1; req_tgl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat_a.valid", 32'(valid), 32'd0);
    end
    tick();
    chk_all("ev_a", 1'b1, 4'hA, 1'b0, 8'd0, 1'b0);
    tick();
    chk_all("acc_a", 1'b0, 4'hA, 1'b1, 8'd1, 1'b0);

    // Event held by ready=0 for 6 cycles
    ready = 1'b0; req_data = 4'h5; req_tgl = 1'b0;
    repeat (4) tick();
    chk_all("ev_5", 1'b1, 4'h5, 1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all("hold_5", 1'b1, 4'h5, 1'b1, 8'd1, 1'b0);
    end
    ready = 1'b1;
    tick();
    chk_all("acc_5", 1'b0, 4'h5, 1'b0, 8'd2, 1'b0);

    // Protocol violation: second flip while VALID and not ready
    ready = 1'b0; req_data = 4'h6; req_tgl = 1'b1;
    repeat (4) tick();
    chk_all("ev_6", 1'b1, 4'h6, 1'b0, 8'd2, 1'b0);
    req_data = 4'h9; req_tgl = 1'b0;
    repeat (3) tick();
    chk_all("viol_pre", 1'b1, 4'h6, 1'b0, 8'd2, 1'b0);
    tick();
    chk_all("viol", 1'b1, 4'h6, 1'b0, 8'd2, 1'b1);
    repeat (2) tick();
    chk_all("viol_hold", 1'b1, 4'h6, 1'b0, 8'd2, 1'b1);
    ready = 1'b1;
    tick();
    chk_all("viol_acc", 1'b0, 4'h6, 1'b1, 8'd3, 1'b1);
    repeat (4) tick();
    chk_all("viol_drop", 1'b0, 4'h6, 1'b1, 8'd3, 1'b1);

    // Only reset clears err
    r = 1'b1; ready = 1'b0;
    tick();
    r = 1'b0;
    chk_all("rst_err", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    repeat (5) tick();
    chk_all("rst_quiet", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);

    // Back-to-back: second chg lands on the ready=1 edge
    req_data = 4'h3; req_tgl = 1'b1;
    repeat (4) tick();
    chk_all("b2b_3", 1'b1, 4'h3, 1'b0, 8'd0, 1'b0);
    req_data = 4'hC; req_tgl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("b2b_wait", 1'b1, 4'h3, 1'b0, 8'd0, 1'b0);
    end
    ready = 1'b1;
    tick();
    chk_all("b2b_c", 1'b1, 4'hC, 1'b1, 8'd1, 1'b0);
    tick();
    chk_all("b2b_end", 1'b0, 4'hC, 1'b0, 8'd2, 1'b0);

    // 256 accepted events: counter wraps, ack returns to 0
    r = 1'b1; ready = 1'b1;
    tick();
    r = 1'b0;
    for (int i = 0; i < 256; i++) begin
      req_data = 4'(i);
      req_tgl  = ~req_tgl;
      repeat (5) tick();
      if (i == 254) chk("wrap_255.cnt", 32'(event_count), 32'd255);
    end
    chk_all("wrap", 1'b0, 4'hF, 1'b0, 8'd0, 1'b0);

    // Reset while VALID discards the event
    req_data = 4'h7; req_tgl = ~req_tgl;
    repeat (5) tick();
    chk_all("pre_rst", 1'b0, 4'h7, 1'b1, 8'd1, 1'b0);
    ready = 1'b0; req_data = 4'h8; req_tgl = ~req_tgl;
    repeat (4) tick();
    chk_all("pre_rst_v", 1'b1, 4'h8, 1'b1, 8'd1, 1'b0);
    r = 1'b1;
    tick();
    r = 1'b0;
    chk_all("rst_valid", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    repeat (6) tick();
    chk_all("rst_drop", 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);

    // A req_tgl held high through reset is one event afterwards
    r = 1'b1; req_tgl = 1'b1; req_data = 4'hE;
    tick();
    r = 1'b0;
    repeat (3) tick();
    chk("rst_lvl_pre.valid", 32'(valid), 32'd0);
    tick();
    chk_all("rst_lvl", 1'b1, 4'hE, 1'b0, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_handshake_responder.md
Name: toggle_handshake_responder

Overview:
- Receive end of a two-phase (toggle) request/acknowledge link. The initiator flips a toggle flip-flop to post one event and holds its data word stable.
- This block synchronizes the toggle, detects the flip, and presents the data to a local consumer with a valid/ready handshake.
- When the consumer accepts, it flips its own acknowledge toggle back to the initiator and counts completed events.

Parameters:
- SYNC_STAGES, 2, flops in the req_tgl synchronizer chain (minimum 2).
- DATA_W, 4, width of the request data word.
- CNT_W, 8, width of the completed-event counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- r  in  1  reset; synchronous, active-high.
- req_tgl  in  1  request toggle from the initiator; each level change is one request. May be asynchronous to clk.
- req_data  in  DATA_W  request data; held stable by the initiator from the toggle flip until ack_tgl flips back.
- ready  in  1  consumer ready.
- valid  out  1  event data available on data.
- data  out  DATA_W  captured request data.
- ack_tgl  out  1  acknowledge toggle; flips once per accepted event.
- event_count  out  CNT_W  number of accepted events.
- busy  out  1  equals valid.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: when r=1 at a rising clk edge, the following all go to 0: synchronizer flops, prev-level register, state (IDLE), valid, data, ack_tgl, event_count, err.
  - Both link ends share r. A req_tgl still at 1 after reset is seen as one event.
  - Reset mid-event discards that event; no ack flip occurs.
- Synchronizer: req_tgl passes through SYNC_STAGES flops; the last stage is sync_q.
- Edge detect: prev <= sync_q every cycle. chg = sync_q XOR prev, a one-cycle pulse per flip.
- Latency: with SYNC_STAGES=2, valid rises at the 4th rising edge after the edge that first samples the new req_tgl level.
  - That edge is stage 1; stage 2 follows; chg is visible in the cycle after that.
  - In general, latency is SYNC_STAGES+2 edges.
- States: IDLE, VALID.
- IDLE:
  - chg=1 -> data <= req_data, valid <= 1, go to VALID.
  - Otherwise hold.
- VALID:
  - valid and data are held stable until ready=1.
  - ready=1 at an edge:
    - ack_tgl <= ~ack_tgl.
    - event_count <= event_count+1, wrapping modulo 2^CNT_W with no saturation or flag.
    - If chg=0 in the same cycle -> valid <= 0, go to IDLE.
    - If chg=1 in the same cycle -> back-to-back accept: data <= req_data, stay in VALID with valid=1, err unchanged.
  - ready=0 and chg=1 -> protocol violation: err <= 1 (sticky until r).
    - The new flip is dropped; no ack flip is issued for it.
    - data is not overwritten.
- ready is ignored in IDLE.
- data is captured only on chg. req_data is never re-sampled while in VALID.
- busy = valid, combinational.
- No other outputs are combinational.

Decomposition:
- Shared package:
  - state enumeration (IDLE=1'b0, VALID=1'b1);
  - default constants for SYNC_STAGES, DATA_W, CNT_W;
  - a MIN_SYNC_STAGES=2 constant for parameter checks.
- Sub-module toggle_sync (clk, r, async input -> sync_q, chg): holds the synchronizer chain and prev/XOR edge detect. It is reusable by the matching initiator for its ack_tgl return path.
- The top level holds the FSM, data register, ack toggle and counter.

Test Plan:
- Reset release with req_tgl=0, ready=0, run 10 cycles -> valid=0, ack_tgl=0, event_count=0, err=0 throughout.
- req_data=4'hA, flip req_tgl 0->1, ready=1 -> valid high for exactly 1 cycle, 4 edges after sampling, with data=4'hA. ack_tgl goes 0->1 and event_count goes 0->1.
- Flip req_tgl with req_data=4'h5, hold ready=0 for 6 cycles, then ready=1 -> valid and data=4'h5 stable the whole hold. A single ack flip occurs; event_count increments by 1.
- In VALID with ready=0, flip req_tgl again -> err=1 and stays 1; data unchanged; after ready=1 exactly one ack flip occurs. err clears only on r.
- Back-to-back: second flip timed so chg coincides with the ready=1 edge, data 4'h3 then 4'hC -> valid stays high, data goes 3->C, two ack flips in total, err=0.
- 256 accepted events with CNT_W=8 -> event_count wraps to 0; ack_tgl ends at 0; no err.
- r asserted while in VALID -> next cycle valid=0, state IDLE, ack_tgl=0, event_count=0.
